clk_freq_meter: RTL

//   Measures the frequency of a slower, asynchronous clock-like input (e.g. a clkdiv

---
 rtl/clk_freq_meter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/clk_freq_meter.sv
// Frequency meter: counts synchronized rising edges of clk_in over back-to-back
// windows of GATE_CYCLES clk cycles and publishes one count per window.
//
// state   | meaning
// IDLE    | stopped, counters cleared, waiting for en
// SETTLE  | flushing synchronizer history, edges ignored
// MEASURE | counting edges inside the gate window
module clk_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [GW-1:0]    G_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_q;

  logic [1:0]       state;
  logic [SW-1:0]    scnt;
  logic [GW-1:0]    gcnt;
  logic [CNT_W-1:0] ecnt;
  logic             ovf_acc;

  logic [CNT_W:0]   sum;
  logic             sat_hit;
  logic [CNT_W-1:0] sum_sat;

  // The reset input is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync   <= '0;
      prev   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], clk_in};
      prev   <= sync[SYNC_STAGES-1];
      edge_q <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

  // ecnt is held at C_MAX, so a carry out means the count saturated.
  assign sum     = {1'b0, ecnt} + {{CNT_W{1'b0}}, edge_q};
  assign sat_hit = sum[CNT_W];
  assign sum_sat = sat_hit ? C_MAX : sum[CNT_W-1:0];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      scnt       <= '0;
      gcnt       <= '0;
      ecnt       <= '0;
      ovf_acc    <= 1'b0;
      freq_cnt   <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          gcnt    <= '0;
          ecnt    <= '0;
          ovf_acc <= 1'b0;
          scnt    <= '0;
          if (en) state <= SETTLE;
        end
        SETTLE: begin
          if (!en) begin
            state <= IDLE;
          end else if (scnt == S_LAST) begin
            state   <= MEASURE;
            gcnt    <= '0;
            ecnt    <= '0;
            ovf_acc <= 1'b0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        MEASURE: begin
          if (!en) begin
            state   <= IDLE;
            gcnt    <= '0;
            ecnt    <= '0;
            ovf_acc <= 1'b0;
          end else if (gcnt == G_LAST) begin
            // Terminal-cycle edge lands in the closing window; next window starts at once.
            freq_cnt   <= sum_sat;
            overflow   <= ovf_acc | sat_hit;
            freq_valid <= 1'b1;
            gcnt       <= '0;
            ecnt       <= '0;
            ovf_acc    <= 1'b0;
          end else begin
            gcnt    <= gcnt + 1'b1;
            ecnt    <= sum_sat;
            ovf_acc <= ovf_acc | sat_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
